// File: rtl/adder_bist_pkg.sv
// rtl/adder_bist_pkg.sv - shared types and constants for the adder BIST controller
package adder_bist_pkg;

  localparam int VEC_W       = 9;
  localparam int RES_W       = 5;
  localparam int DEF_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } bist_state_e;

  // Full 5-bit sum of the vector {cin, b, a}; the carry is kept, never truncated.
  function automatic logic [RES_W-1:0] expected_sum(input logic [VEC_W-1:0] vec);
    return {1'b0, vec[3:0]} + {1'b0, vec[7:4]} + {4'b0000, vec[8]};
  endfunction

endpackage

// File: rtl/adder_bist_ctrl_exp_delay_line.sv
// rtl/adder_bist_ctrl_exp_delay_line.sv - fixed-depth delay line with valid bit
module exp_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             s_tvalid,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  output logic [WIDTH-1:0] m_tdata
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else if (clr) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= s_tvalid;
      dat_q[0] <= s_tdata;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign m_tvalid = vld_q[DEPTH-1];
  assign m_tdata  = dat_q[DEPTH-1];

endmodule

// File: rtl/adder_bist_ctrl.sv
// rtl/adder_bist_ctrl.sv - exhaustive 4-bit adder self-test sequencer and checker
module adder_bist_ctrl
  import adder_bist_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [3:0]       a_out,
  output logic [3:0]       b_out,
  output logic             cin_out,
  input  logic [4:0]       c_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [8:0]       first_fail
);

  localparam int DRAIN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(LATENCY - 1);
  localparam int PIPE_W = VEC_W + RES_W;

  bist_state_e        state_q, state_d;
  logic               start_run;
  logic [VEC_W-1:0]   vec_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               cmp_valid;
  logic [PIPE_W-1:0]  cmp_data;
  logic [VEC_W-1:0]   cmp_idx;
  logic [RES_W-1:0]   cmp_exp;
  logic               mismatch;

  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          start_run = 1'b1;
        end
      end
      ST_RUN:   if (vec_cnt == '1) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // vec_cnt doubles as the operand register; it wraps to 0 leaving RUN so
  // the operands read 0 outside RUN without extra gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (start_run) vec_cnt <= '0;
      else if (state_q == ST_RUN) vec_cnt <= vec_cnt + 1'b1;
      if (state_q == ST_DRAIN && drain_cnt != DRAIN_LAST) drain_cnt <= drain_cnt + 1'b1;
      else drain_cnt <= '0;
    end
  end

  exp_delay_line #(
    .DEPTH (LATENCY),
    .WIDTH (PIPE_W)
  ) u_exp_delay_line (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_run),
    .s_tvalid (state_q == ST_RUN),
    .s_tdata  ({vec_cnt, expected_sum(vec_cnt)}),
    .m_tvalid (cmp_valid),
    .m_tdata  (cmp_data)
  );

  assign cmp_idx  = cmp_data[PIPE_W-1:RES_W];
  assign cmp_exp  = cmp_data[RES_W-1:0];
  assign mismatch = cmp_valid && (cmp_exp != c_in);

  // A zero error count marks the first mismatch of the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count  <= '0;
      first_fail <= '0;
    end else if (start_run) begin
      err_count  <= '0;
      first_fail <= '0;
    end else if (mismatch) begin
      if (err_count == '0) first_fail <= cmp_idx;
      if (err_count != '1) err_count <= err_count + 1'b1;
    end
  end

  assign a_out   = vec_cnt[3:0];
  assign b_out   = vec_cnt[7:4];
  assign cin_out = vec_cnt[8];
  assign busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done    = (state_q == ST_DONE);
  assign pass    = done && (err_count == '0);

endmodule

// File: doc/adder_bist_ctrl.md
ADDER_BIST_CTRL -- requirements
Module: adder_bist_ctrl

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, meaning cycles from an operand appearing on a_out/b_out/cin_out to the matching result being valid on c_in.
REQ-002 The block SHALL have parameter ERR_W, default 8, meaning width of the saturating mismatch counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, run request, sampled in IDLE or DONE only.
REQ-006 The block SHALL have port a_out, output, 4, operand A driven to the registered adder.
REQ-007 The block SHALL have port b_out, output, 4, operand B driven to the registered adder.
REQ-008 The block SHALL have port cin_out, output, 1, carry-in driven to the registered adder.
REQ-009 The block SHALL have port c_in, input, 5, adder result {carry, sum[3:0]}.
REQ-010 The block SHALL have port busy, output, 1, high in RUN and DRAIN.
REQ-011 The block SHALL have port done, output, 1, level, high in DONE.
REQ-012 The block SHALL have port pass, output, 1, high in DONE when err_count is 0.
REQ-013 The block SHALL have port err_count, output, ERR_W, saturating mismatch count.
REQ-014 The block SHALL have port first_fail, output, 9, vector index {cin,b,a} of the first mismatch.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-016 start high in IDLE or DONE SHALL move the FSM to RUN on that edge and clear the vector counter, err_count, first_fail and the expected pipeline.
REQ-017 start SHALL be ignored in RUN and DRAIN.
REQ-018 In RUN, a 9-bit vector counter SHALL present one vector per cycle: a_out=cnt[3:0], b_out=cnt[7:4], cin_out=cnt[8], all registered, starting at 0 in the first RUN cycle.
REQ-019 After vector 511 is presented, the FSM SHALL enter DRAIN for exactly LATENCY cycles, then enter DONE.
REQ-020 a_out, b_out and cin_out SHALL be 0 in every state except RUN.
REQ-021 For each presented vector the block SHALL compute the 5-bit expected value a+b+cin without truncation and carry it through a LATENCY-deep pipeline with a valid bit.
REQ-022 A vector presented in cycle n SHALL be compared with c_in at the end of cycle n+LATENCY; only valid pipeline entries SHALL be compared.
REQ-023 On a mismatch err_count SHALL increment, holding at 2^ERR_W-1 when saturated.
REQ-024 first_fail SHALL capture the index of the first mismatch of a run and hold it; it SHALL be 0 if no mismatch has occurred.
REQ-025 The last comparison SHALL occur in the final DRAIN cycle; done SHALL rise on the following edge.
REQ-026 busy SHALL be high for exactly 512+LATENCY cycles per run.
REQ-027 pass SHALL be 0 outside DONE.
REQ-028 err_count and first_fail SHALL hold in DONE until the next start or reset.

Reset
REQ-029 rst_n low SHALL immediately force IDLE and set every output and register to 0, including the counter and the expected pipeline, in any state.
REQ-030 A reset mid-run SHALL leave no residual valid pipeline entries; after release, no comparison SHALL occur before a new start.

Structure
REQ-031 Package adder_bist_pkg SHALL hold the state enum, VEC_W=9, RES_W=5 and the default LATENCY.
REQ-032 The expected-value pipeline SHALL be one sub-module, exp_delay_line, parameterised by depth and width, with valid propagation and asynchronous clear.

Verification
REQ-033 With a correct LATENCY=2 registered-adder model, a start pulse SHALL give busy for 514 cycles, then done=1, pass=1, err_count=0.
REQ-034 With c_in[0] stuck at 0, the run SHALL end with pass=0, err_count=255 (saturated from 256 odd-sum vectors) and first_fail=9'h001.
REQ-035 With c_in forced to 0 and ERR_W=10, the run SHALL end with err_count=511 and first_fail=9'h001.
REQ-036 A start pulse at vector 100 during RUN SHALL change nothing; a start in DONE SHALL clear err_count, first_fail and done, and present vector 0 next cycle.
REQ-037 rst_n low at vector 100 SHALL make a_out, b_out, cin_out, busy, done and err_count 0 before the next clock edge; after release the FSM SHALL stay in IDLE with no comparisons.
REQ-038 A model with 3-cycle latency and LATENCY=2 SHALL end with pass=0 and err_count nonzero.
